// File: rtl/fifo_stream_pkg.sv
// Shared state encoding and sizing helpers for the FIFO stream reader.
// Used by fifo_stream_reader and, when STREAM_LAST_EN is defined, frame_beat_counter.
package fifo_stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Number of narrow beats carried by one FIFO word.
    function automatic int calc_ratio(input int in_width, input int out_width);
        return in_width / out_width;
    endfunction

    // Index width for a count of n, never narrower than one bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Counts accepted stream beats and flags the final beat of each BURST_LEN frame.
// Compiled only when STREAM_LAST_EN is defined, which is the only build that uses it.
`ifdef STREAM_LAST_EN
module frame_beat_counter
    import fifo_stream_pkg::*;
#(
    parameter int BURST_LEN = 16
) (
    input  logic read_clk,
    input  logic read_rst_n,
    input  logic accept,
    output logic last
);

    localparam int             CNT_W   = calc_idx_w(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;

    assign last = (beat_cnt_q == CNT_MAX);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = last ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge read_clk) begin
        if (!read_rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
`endif

// File: rtl/fifo_stream_reader.sv
// Drains wide FIFO words into a narrow valid/ready stream, LSB slice first, popping back-to-back.
// Define STREAM_LAST_EN to add beat counting and the m_last frame marker port.
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter int BURST_LEN = 16
) (
    input  logic                 read_clk,
    input  logic                 read_rst_n,
    input  logic                 run,
    input  logic                 fifo_empty,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 fifo_rd_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
`ifdef STREAM_LAST_EN
    output logic                 m_last,
`endif
    output logic                 busy
);

    localparam int                     RATIO       = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int                     SLICE_IDX_W = calc_idx_w(RATIO);
    localparam logic [SLICE_IDX_W-1:0] LAST_IDX    = SLICE_IDX_W'(RATIO - 1);

    state_e                  state_q, state_d;
    logic [SLICE_IDX_W-1:0]  slice_idx_q, slice_idx_d;
    logic [IN_WIDTH-1:0]     word_q, word_d;

    logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
    logic accept;
    logic last_slice;
    logic pop;

    assign slices     = word_q;
    assign m_valid    = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign m_data     = slices[slice_idx_q];
    assign accept     = m_valid & m_ready;
    assign last_slice = (slice_idx_q == LAST_IDX);

    // A refill pop can coincide with the last-slice accept, which is what removes the bubble.
    assign pop        = run & ~fifo_empty & ((state_q == IDLE) | (accept & last_slice));
    assign fifo_rd_en = pop & read_rst_n;

    // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        slice_idx_d = slice_idx_q;
        word_d      = word_q;
        if (pop) begin
            word_d      = fifo_data;
            slice_idx_d = '0;
            state_d     = SEND;
        end else if (accept) begin
            if (last_slice) begin
                state_d     = IDLE;
                slice_idx_d = '0;
            end else begin
                slice_idx_d = slice_idx_q + SLICE_IDX_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments; the data word is cleared on reset
    // too, so m_data is deterministic straight out of reset.
    always_ff @(posedge read_clk) begin
        if (!read_rst_n) begin
            state_q     <= IDLE;
            slice_idx_q <= '0;
            word_q      <= '0;
        end else begin
            state_q     <= state_d;
            slice_idx_q <= slice_idx_d;
            word_q      <= word_d;
        end
    end

`ifdef STREAM_LAST_EN
    logic beat_last;

    frame_beat_counter #(
        .BURST_LEN (BURST_LEN)
    ) u_frame_beat_counter (
        .read_clk   (read_clk),
        .read_rst_n (read_rst_n),
        .accept     (accept),
        .last       (beat_last)
    );

    assign m_last = m_valid & beat_last;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed self-checking bench for fifo_stream_reader with a queue-backed first-word-fall-through FIFO.
// The frame-marker steps run only when STREAM_LAST_EN is defined.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

    logic         read_clk = 1'b0;
    logic         read_rst_n;
    logic         run;
    logic         fifo_empty;
    logic [511:0] fifo_data;
    logic         fifo_rd_en;
    logic         m_valid;
    logic         m_ready;
    logic [63:0]  m_data;
    logic         busy;
`ifdef STREAM_LAST_EN
    logic         m_last;
`endif

    logic [511:0] fifo_q[$];
    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;

    fifo_stream_reader dut (
        .read_clk   (read_clk),
        .read_rst_n (read_rst_n),
        .run        (run),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
`ifdef STREAM_LAST_EN
        .m_last     (m_last),
`endif
        .busy       (busy)
    );

    always #5 read_clk = ~read_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Byte k of a word is seed+k, so slice s byte j is seed+8s+j.
    function automatic logic [511:0] make_word(input logic [7:0] seed);
        logic [511:0] w;
        for (int k = 0; k < 64; k++) w[8*k +: 8] = seed + 8'(k);
        return w;
    endfunction

    function automatic logic [63:0] exp_slice(input logic [7:0] seed, input int s);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = seed + 8'(8*s + j);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic load(input logic [7:0] seed);
        fifo_q.push_back(make_word(seed));
        refresh();
    endtask

    // Samples the pop strobe, advances one clock, then retires the popped word.
    task automatic tick();
        logic rd_s;
        rd_s = fifo_rd_en;
        if (rd_s) check("pop_while_empty", 64'(fifo_empty), 64'd0);
        @(posedge read_clk);
        #1;
        if (rd_s) begin
            pop_cnt++;
            if (fifo_q.size() > 0) fifo_q.delete(0);
        end
        refresh();
        #1;
    endtask

    logic [7:0] s3 [4];
    logic [7:0] s2 [2];
    logic       pat [6];
    int         base;
    int         beat;
    int         cyc;

    initial begin
        read_rst_n = 1'b0;
        run        = 1'b1;
        m_ready    = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        load(8'h00);

        // 1: reset held five cycles with a non-empty FIFO
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
            check("rst_valid", 64'(m_valid), 64'd0);
            check("rst_busy",  64'(busy), 64'd0);
        end
        check("rst_data", m_data, 64'd0);
        read_rst_n = 1'b1;
        #1;
        check("rst_release_pop", 64'(fifo_rd_en), 64'd1);
        tick();

        // 2: single word drains as eight consecutive beats
        #1;
        check("t2_beat0_const", m_data, 64'h0706050403020100);
        for (int b = 0; b < 8; b++) begin
            #1;
            check("t2_valid", 64'(m_valid), 64'd1);
            check("t2_busy",  64'(busy), 64'd1);
            check("t2_data",  m_data, exp_slice(8'h00, b));
            check("t2_rd_en", 64'(fifo_rd_en), 64'd0);
            tick();
        end
        #1;
        check("t2_idle_valid", 64'(m_valid), 64'd0);
        check("t2_idle_busy",  64'(busy), 64'd0);
        check("t2_pops", 64'(pop_cnt), 64'd1);

        // 3: four preloaded words stream with no bubbles
        s3 = '{8'h10, 8'h40, 8'h70, 8'hA0};
        for (int i = 0; i < 4; i++) load(s3[i]);
        base = pop_cnt;
        for (int c = 0; c < 34; c++) begin
            #1;
            check("t3_rd_en", 64'(fifo_rd_en), 64'((c % 8 == 0) && (c < 32)));
            if (c >= 1 && c <= 32) begin
                check("t3_valid", 64'(m_valid), 64'd1);
                check("t3_data", m_data, exp_slice(s3[(c-1)/8], (c-1) % 8));
            end else begin
                check("t3_idle", 64'(m_valid), 64'd0);
            end
            tick();
        end
        check("t3_pops", 64'(pop_cnt - base), 64'd4);

        // 4: backpressure pattern over two words
        s2  = '{8'h55, 8'hC3};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        load(s2[0]);
        load(s2[1]);
        base = pop_cnt;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 100) begin
            m_ready = pat[cyc % 6];
            #1;
            if (m_valid) begin
                check("t4_data", m_data, exp_slice(s2[beat/8], beat % 8));
                if (m_ready) beat++;
            end
            tick();
            cyc++;
        end
        check("t4_all_beats", 64'(beat), 64'd16);
        check("t4_pops", 64'(pop_cnt - base), 64'd2);
        m_ready = 1'b1;
        #1;
        check("t4_idle", 64'(m_valid), 64'd0);

        // 5: run dropped while slice 3 is accepted
        load(8'h20);
        load(8'h90);
        base = pop_cnt;
        #1;
        check("t5_first_pop", 64'(fifo_rd_en), 64'd1);
        tick();
        for (int b = 0; b < 8; b++) begin
            if (b == 3) run = 1'b0;
            #1;
            check("t5_valid", 64'(m_valid), 64'd1);
            check("t5_data", m_data, exp_slice(8'h20, b));
            check("t5_rd_en", 64'(fifo_rd_en), 64'd0);
            tick();
        end
        #1;
        check("t5_busy_after", 64'(busy), 64'd0);
        check("t5_valid_after", 64'(m_valid), 64'd0);
        check("t5_pops", 64'(pop_cnt - base), 64'd1);
        check("t5_left_in_fifo", 64'(fifo_q.size()), 64'd1);
        tick();
        #1;
        check("t5_idle_no_pop", 64'(fifo_rd_en), 64'd0);
        fifo_q.delete();
        refresh();

        // Reset while a word is held discards it
        run = 1'b1;
        m_ready = 1'b0;
        load(8'h33);
        tick();
        fifo_q.delete();
        refresh();
        #1;
        check("mid_rst_held", 64'(m_valid), 64'd1);
        read_rst_n = 1'b0;
        tick();
        #1;
        check("mid_rst_valid", 64'(m_valid), 64'd0);
        check("mid_rst_busy",  64'(busy), 64'd0);
        check("mid_rst_data",  m_data, 64'd0);
        read_rst_n = 1'b1;
        m_ready = 1'b1;

`ifdef STREAM_LAST_EN
        // 6: frame marker every 16 beats, restarted by reset
        load(8'h01);
        load(8'h41);
        load(8'h81);
        beat = 0;
        cyc  = 0;
        while (beat < 24 && cyc < 100) begin
            #1;
            if (m_valid) begin
                check("t6_last", 64'(m_last), 64'(beat == 15));
                beat++;
            end
            tick();
            cyc++;
        end
        check("t6_beats", 64'(beat), 64'd24);
        read_rst_n = 1'b0;
        tick();
        tick();
        read_rst_n = 1'b1;
        load(8'h11);
        load(8'h51);
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 100) begin
            #1;
            if (m_valid) begin
                check("t6_last_after_rst", 64'(m_last), 64'(beat == 15));
                beat++;
            end
            tick();
            cyc++;
        end
        check("t6_beats_after_rst", 64'(beat), 64'd16);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
